// File: rtl/poc_fetch_unit_if.sv
// Fetch-unit control/data bundle between the control unit and the fetch datapath.
// Latency: none, wires only.
// Backpressure: none; strobes are level-sensitive micro-operations.
interface poc_fetch_unit_if #(
    parameter int ADDR_W = 9,
    parameter int WORD_W = 9
);
    logic                  pc_write;
    logic                  pc_inc;
    logic [ADDR_W-1:0]     pc_din;
    logic [ADDR_W-1:0]     pc_dout;
    logic                  iar_write;
    logic                  iar_inc;
    logic [ADDR_W-1:0]     iar_dout;
    logic [WORD_W-1:0]     imem_din;
    logic                  idr_write;
    logic [2*WORD_W-1:0]   idr_dout1;
    logic [WORD_W-1:0]     idr_dout2;

    // Control unit / instruction RAM side
    modport master (
        output pc_write, pc_inc, pc_din,
        output iar_write, iar_inc,
        output imem_din, idr_write,
        input  pc_dout, iar_dout, idr_dout1, idr_dout2
    );

    // Fetch datapath side
    modport slave (
        input  pc_write, pc_inc, pc_din,
        input  iar_write, iar_inc,
        input  imem_din, idr_write,
        output pc_dout, iar_dout, idr_dout1, idr_dout2
    );
endinterface

// File: rtl/poc_fetch_unit.sv
// POC instruction fetch: PC -> IAR -> instruction RAM -> 3-word IDR shift register.
// Latency: one cycle from strobe to visible register output; outputs are pure flops.
// Backpressure: none; every strobe acts on each edge it is held high.
module poc_fetch_unit #(
    parameter int                ADDR_W   = 9,
    parameter int                WORD_W   = 9,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    poc_fetch_unit_if.slave  bus
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_iar;
    logic [WORD_W-1:0] r_idr_w0;
    logic [WORD_W-1:0] r_idr_w1;
    logic [WORD_W-1:0] r_idr_w2;

    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_iar_nxt;

    // Next PC: a load (branch target) wins over sequential increment
    always_comb begin
        w_pc_nxt = r_pc;
        if (bus.pc_write == 1'b1) begin
            w_pc_nxt = bus.pc_din;
        end else if (bus.pc_inc == 1'b1) begin
            w_pc_nxt = r_pc + ADDR_W'(1);
        end
    end

    // Next IAR: copies the pre-edge PC so iar_write can share a cycle with pc_inc
    always_comb begin
        w_iar_nxt = r_iar;
        if (bus.iar_write == 1'b1) begin
            w_iar_nxt = r_pc;
        end else if (bus.iar_inc == 1'b1) begin
            w_iar_nxt = r_iar + ADDR_W'(1);
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    // IAR register; its value addresses the instruction RAM directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iar <= '0;
        end else begin
            r_iar <= w_iar_nxt;
        end
    end

    // IDR: shift in the word read at the pre-edge IAR, keeping the two older words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idr_w0 <= '0;
            r_idr_w1 <= '0;
            r_idr_w2 <= '0;
        end else if (bus.idr_write == 1'b1) begin
            r_idr_w2 <= r_idr_w1;
            r_idr_w1 <= r_idr_w0;
            r_idr_w0 <= bus.imem_din;
        end
    end

    assign bus.pc_dout   = r_pc;
    assign bus.iar_dout  = r_iar;
    assign bus.idr_dout1 = {r_idr_w2, r_idr_w1};
    assign bus.idr_dout2 = r_idr_w0;

endmodule

// File: tb/tb_poc_fetch_unit.sv
// Self-checking bench for poc_fetch_unit: directed steps then random strobes
// compared against a register-level reference model of the fetch rules.
module tb_poc_fetch_unit;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    poc_fetch_unit_if #(.ADDR_W(9), .WORD_W(9)) bus ();

    poc_fetch_unit #(.ADDR_W(9), .WORD_W(9), .PC_RESET(9'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Combinational instruction RAM addressed by the IAR
    logic [8:0] ram [512];
    assign bus.imem_din = ram[bus.iar_dout];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [8:0] m_pc, m_iar;
    logic [8:0] m_w [3];

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},   18'(bus.pc_dout),   18'(m_pc));
        check({tag, ".iar"},  18'(bus.iar_dout),  18'(m_iar));
        check({tag, ".idr1"}, 18'(bus.idr_dout1), {m_w[2], m_w[1]});
        check({tag, ".idr2"}, 18'(bus.idr_dout2), 18'(m_w[0]));
    endtask

    task automatic model_reset();
        m_pc = 9'd0;
        m_iar = 9'd0;
        for (int k = 0; k < 3; k++) m_w[k] = 9'd0;
    endtask

    // One clock: drive strobes, step the model on the edge, check on the falling edge
    task automatic cyc(input string tag, input bit pw, input bit pi, input logic [8:0] pd,
                       input bit iw, input bit ii, input bit dw);
        logic [8:0] old_pc, old_iar, word;
        bus.pc_write  = pw;
        bus.pc_inc    = pi;
        bus.pc_din    = pd;
        bus.iar_write = iw;
        bus.iar_inc   = ii;
        bus.idr_write = dw;
        @(posedge clk);
        old_pc  = m_pc;
        old_iar = m_iar;
        word    = ram[old_iar];
        if (!rst_n) begin
            model_reset();
        end else begin
            if (pw)      m_pc = pd;
            else if (pi) m_pc = 9'((int'(old_pc) + 1) % 512);
            if (iw)      m_iar = old_pc;
            else if (ii) m_iar = 9'((int'(old_iar) + 1) % 512);
            if (dw) begin
                m_w[2] = m_w[1];
                m_w[1] = m_w[0];
                m_w[0] = word;
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    // Pulse reset between edges and confirm outputs clear without a clock edge
    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 512; k++) ram[k] = 9'($urandom_range(0, 511));
        ram[6] = 9'h1A5;
        model_reset();

        // Reset held with every strobe active
        @(negedge clk);
        for (int k = 0; k < 3; k++) cyc("rst_hold", 1, 1, 9'h1FF, 1, 1, 1);
        rst_n = 1'b1;
        cyc("rst_release", 0, 0, 9'h0, 0, 0, 0);
        cyc("rst_idle", 0, 0, 9'h0, 0, 0, 0);

        // Fetch sequence
        cyc("fetch_load", 1, 0, 9'd6, 0, 0, 0);
        check("fetch_pc6", 18'(bus.pc_dout), 18'd6);
        cyc("fetch_iar", 0, 1, 9'd0, 1, 0, 0);
        check("fetch_iar6", 18'(bus.iar_dout), 18'd6);
        check("fetch_pc7", 18'(bus.pc_dout), 18'd7);
        cyc("fetch_idr", 0, 0, 9'd0, 0, 0, 1);
        check("fetch_word", 18'(bus.idr_dout2), 18'h1A5);

        // Asynchronous reset mid-fetch
        async_reset("async_mid");

        // Priority
        cyc("prio_pc", 1, 1, 9'd100, 0, 0, 0);
        check("prio_pc100", 18'(bus.pc_dout), 18'd100);
        cyc("prio_pc20", 1, 0, 9'd20, 0, 0, 0);
        cyc("prio_iar", 0, 0, 9'd0, 1, 1, 0);
        check("prio_iar20", 18'(bus.iar_dout), 18'd20);

        // Wrap
        cyc("wrap_load", 1, 0, 9'd511, 0, 0, 0);
        cyc("wrap_pc", 0, 1, 9'd0, 0, 0, 0);
        check("wrap_pc0", 18'(bus.pc_dout), 18'd0);
        cyc("wrap_load2", 1, 0, 9'd511, 0, 0, 0);
        cyc("wrap_iarld", 0, 0, 9'd0, 1, 0, 0);
        cyc("wrap_iar", 0, 0, 9'd0, 0, 1, 0);
        check("wrap_iar0", 18'(bus.iar_dout), 18'd0);

        // IDR shift: multi-word fetch from addresses 0,1,2
        ram[0] = 9'h011;
        ram[1] = 9'h022;
        ram[2] = 9'h033;
        for (int k = 0; k < 3; k++) cyc("shift", 0, 0, 9'd0, 0, 1, 1);
        check("shift_w0", 18'(bus.idr_dout2), 18'h033);
        check("shift_w21", 18'(bus.idr_dout1), {9'h011, 9'h022});
        cyc("shift_hold", 0, 0, 9'd0, 0, 1, 0);
        check("shift_hold_w21", 18'(bus.idr_dout1), {9'h011, 9'h022});

        // Held strobe acts once per edge
        cyc("inc_base", 1, 0, 9'd40, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc("inc_held", 0, 1, 9'd0, 0, 0, 0);
        check("inc_held43", 18'(bus.pc_dout), 18'd43);

        // Random strobes
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                async_reset("rand_async");
            end else begin
                cyc("rand",
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 1) == 1,
                    9'($urandom_range(0, 511)),
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 1) == 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/poc_fetch_unit.md
Name: poc_fetch_unit

Overview:
Instruction-fetch datapath for the POC processor. It contains three registers: the program counter (PC), the instruction address register (IAR) and the instruction data register (IDR).
- The PC feeds the IAR.
- The IAR drives the external instruction-RAM address.
- The IDR captures words returned by the combinational instruction RAM and presents them to decode.
- All register updates are controlled by control-unit micro-operation strobes (write/inc).

Parameters:
ADDR_W, 9, width of PC, IAR and instruction-RAM address
WORD_W, 9, width of one instruction-memory word
PC_RESET, 0, value loaded into PC on reset

Ports:
clk  input  1  system clock; all registers update on rising edge
rst_n  input  1  asynchronous active-low reset
pc_write  input  1  load PC from pc_din
pc_inc  input  1  increment PC by 1
pc_din  input  ADDR_W  PC load value (branch/jump target)
pc_dout  output  ADDR_W  current PC value
iar_write  input  1  load IAR from current PC
iar_inc  input  1  increment IAR by 1
iar_dout  output  ADDR_W  current IAR; drives instruction-RAM addr
imem_din  input  WORD_W  data returned by instruction RAM (combinational read of iar_dout)
idr_write  input  1  capture imem_din into IDR
idr_dout1  output  2*WORD_W  {idr_w2, idr_w1}: two older captured words
idr_dout2  output  WORD_W  idr_w0: most recently captured word

Behaviour:
Reset:
- rst_n low immediately forces PC=PC_RESET, IAR=0, idr_w0=idr_w1=idr_w2=0, independent of clk.
- Release is synchronous in effect: the first update occurs on the first rising edge with rst_n high.
- Reset asserted mid-operation overrides all strobes.

PC (rising edge):
- pc_write=1: PC<=pc_din.
- Else pc_inc=1: PC<=PC+1, modulo 2^ADDR_W (511+1 wraps to 0).
- Else hold.
- pc_write has priority over pc_inc.

IAR (rising edge):
- iar_write=1: IAR<=PC, using the PC value before this edge's PC update.
- Else iar_inc=1: IAR<=IAR+1, modulo 2^ADDR_W.
- Else hold.
- This lets iar_write and pc_inc be asserted in the same cycle: IAR gets the old PC while PC advances.

IDR (rising edge):
- idr_write=1: three-word shift: idr_w2<=idr_w1, idr_w1<=idr_w0, idr_w0<=imem_din.
- Else hold.
- Multi-word instructions (opcode plus operands) are fetched by repeated iar_inc/idr_write cycles.

Timing and outputs:
- All outputs are direct register outputs: no combinational path from inputs to outputs, one-cycle latency from strobe to visible value.
- imem_din is sampled at the edge, so the word captured is the RAM contents at the IAR value held before that edge.
- Strobes are level-sensitive: a strobe held for N cycles acts N times (e.g. pc_inc held 3 cycles adds 3).
- X/undriven strobes are a bench error; the RTL treats non-1 values as 0 where synthesizable.

Test Plan:
1. Reset: hold rst_n=0 with strobes active across several edges -> PC=0, IAR=0, idr_dout1=0, idr_dout2=0; release, all strobes 0 -> values held.
2. Fetch sequence:
   - pc_din=6, pc_write=1 for one edge -> pc_dout=6.
   - Next edge with iar_write=1, pc_inc=1 -> iar_dout=6, pc_dout=7.
   - Next edge with idr_write=1, imem_din=RAM[6] (e.g. 9'h1A5) -> idr_dout2=9'h1A5.
3. Priority: pc_write=1 and pc_inc=1 with pc_din=100 -> PC=100 (not 101). iar_write=1 and iar_inc=1 with PC=20 -> IAR=20.
4. Wrap: PC loaded 511, pc_inc one edge -> 0. IAR loaded 511, iar_inc one edge -> 0.
5. IDR shift: three idr_write edges with imem_din=9'h011, 9'h022, 9'h033 -> idr_dout2=9'h033, idr_dout1={9'h011,9'h022}. A fourth edge with idr_write=0 -> unchanged.
6. Async reset mid-fetch: assert rst_n=0 between clock edges while PC=7, IAR=6 -> all outputs 0 before the next edge.
